// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared types and constants for the RV32I fetch stage.
//   NOP_INSTR        canonical bubble (addi x0,x0,0)
//   RESET_PC_DEFAULT default PCF after reset
//   fetch_state_t    fetch FSM states
//   ifid_t           IF/ID pipeline register contents
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus.
//   imem_req    fetch -> mem  request strobe, accepted in the cycle it is high
//   imem_addr   fetch -> mem  request address
//   imem_rvalid mem -> fetch  response valid (>=1 cycle after the request)
//   imem_rdata  mem -> fetch  instruction word
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// fetch_stage_if_id_reg: IF/ID pipeline register.
//   clk, reset  clock, async active-high reset
//   flush       squash to NOP with PC fields cleared (highest priority)
//   stall       hold all fields
//   load        capture din
//   din / q     {instr, pc, pcPlus4, valid}
// With neither flush, stall nor load the register turns into a bubble:
// instr=NOP and valid=0; the PC fields keep their last value.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  flush,
  input  logic  stall,
  input  logic  load,
  input  ifid_t din,
  output ifid_t q
);

  localparam ifid_t IFID_NOP = '{instr: NOP_INSTR, pc: 32'd0, pcPlus4: 32'd0, valid: 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       q <= IFID_NOP;
    else if (flush)  q <= IFID_NOP;
    else if (!stall) begin
      if (load) q <= din;
      else begin
        q.instr <= NOP_INSTR;
        q.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch + IF/ID register.
//   clk, reset   clock, async active-high reset
//   StallD       hold IF/ID and PCF
//   FlushD       squash IF/ID to NOP
//   PCSrcE       redirect from execute; PCTargetE is the target (bits [1:0] ignored)
//   imem         instruction-memory bus (master side), one request outstanding max
//   InstrD, PCD, PCPlus4D, ValidD   decode-stage outputs
// Only XLEN=32 is supported.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  fetch_stage_if.master   imem,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  fetch_state_t    state;
  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] pcPlus4F;
  logic [XLEN-1:0] redirPc;
  logic [XLEN-1:0] bufInstr;
  logic            kill;     // response of the in-flight request belongs to a squashed path
  logic            load;
  logic [XLEN-1:0] loadInstr;
  logic            unusedTgtLsbs;
  ifid_t           ifidIn;
  ifid_t           ifidQ;

  assign pcPlus4F      = pcF + XLEN'(4);  // wraps modulo 2^32
  assign redirPc       = {PCTargetE[XLEN-1:2], 2'b00};
  assign unusedTgtLsbs = ^PCTargetE[1:0];

  // A redirect in REQ suppresses the strobe: the old-path request is never
  // issued, so the target can be requested next cycle without two strobes
  // back to back or an orphan response. Reset gates the strobe so nothing is
  // issued while reset is held.
  assign imem.imem_req  = (state == REQ) && !PCSrcE && !reset;
  assign imem.imem_addr = pcF;

  // Word entering IF/ID this edge: a fresh response or the HOLD buffer.
  always_comb begin
    load      = 1'b0;
    loadInstr = bufInstr;
    if (!PCSrcE && !StallD) begin
      if (state == WAIT && imem.imem_rvalid && !kill) begin
        load      = 1'b1;
        loadInstr = imem.imem_rdata;
      end else if (state == HOLD) begin
        load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= REQ;
      pcF      <= RESET_PC;
      kill     <= 1'b0;
      bufInstr <= NOP_INSTR;
    end else begin
      case (state)
        REQ: begin
          if (PCSrcE) pcF <= redirPc;
          else        state <= WAIT;
        end
        WAIT: begin
          if (PCSrcE) begin
            pcF <= redirPc;
            if (imem.imem_rvalid) begin
              kill  <= 1'b0;   // response arrives now and is dropped
              state <= REQ;
            end else begin
              kill  <= 1'b1;   // drop whatever comes back later
            end
          end else if (imem.imem_rvalid) begin
            kill <= 1'b0;
            if (kill) state <= REQ;
            else if (StallD) begin
              bufInstr <= imem.imem_rdata;
              state    <= HOLD;
            end else begin
              pcF   <= pcPlus4F;
              state <= REQ;
            end
          end
        end
        HOLD: begin
          if (PCSrcE) begin
            pcF   <= redirPc;
            state <= REQ;
          end else if (!StallD) begin
            pcF   <= pcPlus4F;
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  assign ifidIn = '{instr: loadInstr, pc: pcF, pcPlus4: pcPlus4F, valid: 1'b1};

  fetch_stage_if_id_reg uIfId (
    .clk   (clk),
    .reset (reset),
    .flush (FlushD),
    .stall (StallD),
    .load  (load),
    .din   (ifidIn),
    .q     (ifidQ)
  );

  assign InstrD   = ifidQ.instr;
  assign PCD      = ifidQ.pc;
  assign PCPlus4D = ifidQ.pcPlus4;
  assign ValidD   = ifidQ.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed per-cycle vector table, a reset-mid-WAIT sequence,
// and a randomized run against a transaction-level reference model with a
// variable-latency memory responder.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_stage_if #(.XLEN(32)) imemIf ();

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (imemIf),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic br, input logic [31:0] tgt,
                       input logic rv, input logic [31:0] rd);
    StallD = st; FlushD = fl; PCSrcE = br; PCTargetE = tgt;
    imemIf.imem_rvalid = rv; imemIf.imem_rdata = rd;
  endtask

  // One row = one clock cycle. expReq/expAddr are checked inside the cycle,
  // the exp* IF/ID values right after the closing edge.
  typedef struct {
    logic st, fl, br; logic [31:0] tgt; logic rv; logic [31:0] rd;
    logic expReq; logic [31:0] expAddr, expInstr; logic expValid; logic [31:0] expPcD;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic fl, logic br, logic [31:0] tgt, logic rv,
                              logic [31:0] rd, logic er, logic [31:0] ea, logic [31:0] ei,
                              logic ev, logic [31:0] ep);
    vec_t v;
    v.st = st; v.fl = fl; v.br = br; v.tgt = tgt; v.rv = rv; v.rd = rd;
    v.expReq = er; v.expAddr = ea; v.expInstr = ei; v.expValid = ev; v.expPcD = ep;
    return v;
  endfunction

  localparam logic [31:0] N  = 32'h0000_0013;
  localparam logic [31:0] I0 = 32'h00C4_8413;
  localparam logic [31:0] I1 = 32'h0010_0093;
  localparam logic [31:0] I2 = 32'h0020_8113;
  localparam logic [31:0] I3 = 32'h0000_0513;
  localparam logic [31:0] I4 = 32'h00A0_0593;
  localparam logic [31:0] I5 = 32'h00B0_0613;

  // reference model state (transaction level)
  logic [31:0] mPc, bufW, dW, dPc, eI, ePc, eP4;
  logic        outst, disc, buffered, delivered, eV, expReq;
  logic        pend;
  int          pendCnt;
  logic        st, fl, br, rv;
  logic [31:0] tgt, rd;

  initial begin
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    reset = 1'b1;
    #1;
    chk("rst.req", imemIf.imem_req, 1'b0);
    chk("rst.instr", InstrD, N);
    chk("rst.valid", ValidD, 1'b0);
    chk("rst.pcd", PCD, 32'h0);
    chk("rst.p4", PCPlus4D, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    //              st fl br tgt           rv rd            req addr          instr valid pcd
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h0,        N,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            1, I0,           0, 0,            I0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h4,        N,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            1, I1,           0, 0,            I1, 1, 32'h4));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h8,        N,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0,            1, I2,           0, 0,            N,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            N,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            N,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            I2, 1, 32'h8));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'hC,        N,  0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h100,      0, 0,            0, 0,            N,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            N,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            1, 32'hDEADBEEF, 0, 0,            N,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h100,      N,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            1, I3,           0, 0,            I3, 1, 32'h100));
    vecs.push_back(mk(1, 1, 0, 0,            0, 0,            1, 32'h104,      N,  0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h203,      1, 32'hBAD0BAD0, 0, 0,            N,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h200,      N,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            1, I4,           0, 0,            I4, 1, 32'h200));
    vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 0, 0,            0, 0,            N,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'hFFFFFFFC, N,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            1, I5,           0, 0,            I5, 1, 32'hFFFFFFFC));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h0,        N,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            1, I0,           0, 0,            I0, 1, 32'h0));

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].fl, vecs[i].br, vecs[i].tgt, vecs[i].rv, vecs[i].rd);
      #1;
      chk($sformatf("v%0d.req", i), imemIf.imem_req, vecs[i].expReq);
      if (vecs[i].expReq) chk($sformatf("v%0d.addr", i), imemIf.imem_addr, vecs[i].expAddr);
      @(posedge clk); #1;
      chk($sformatf("v%0d.instr", i), InstrD, vecs[i].expInstr);
      chk($sformatf("v%0d.valid", i), ValidD, vecs[i].expValid);
      if (vecs[i].expValid || vecs[i].fl) begin
        chk($sformatf("v%0d.pcd", i), PCD, vecs[i].expPcD);
        chk($sformatf("v%0d.p4", i), PCPlus4D, vecs[i].fl ? 32'h0 : vecs[i].expPcD + 32'd4);
      end
    end

    // reset asserted mid-WAIT; the stale response after release is ignored
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("r6.req", imemIf.imem_req, 1'b1);
    chk("r6.addr", imemIf.imem_addr, 32'h4);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("r6.async.instr", InstrD, N);
    chk("r6.async.valid", ValidD, 1'b0);
    chk("r6.async.pcd", PCD, 32'h0);
    chk("r6.async.p4", PCPlus4D, 32'h0);
    chk("r6.async.req", imemIf.imem_req, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 1, 32'hCAFEF00D);
    #1;
    chk("r6.rel.req", imemIf.imem_req, 1'b1);
    chk("r6.rel.addr", imemIf.imem_addr, 32'h0);
    @(posedge clk); #1;
    chk("r6.stale.valid", ValidD, 1'b0);
    drive(0, 0, 0, 0, 1, I1);
    @(posedge clk); #1;
    chk("r6.ld.instr", InstrD, I1);
    chk("r6.ld.valid", ValidD, 1'b1);
    chk("r6.ld.pcd", PCD, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("r6.next.addr", imemIf.imem_addr, 32'h4);

    // randomized run against the reference model
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mPc = 32'h0; outst = 0; disc = 0; buffered = 0; bufW = 0;
    eI = N; eV = 0; ePc = 0; eP4 = 0; pend = 0; pendCnt = 0;
    for (int k = 0; k < 3000; k++) begin
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 9) == 0);
      br = ($urandom_range(0, 99) < 8);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      rv = 1'b0;
      rd = $urandom;
      if (pend) begin
        if (pendCnt == 1) begin rv = 1'b1; pend = 1'b0; end
        else pendCnt--;
      end
      drive(st, fl, br, tgt, rv, rd);
      #1;
      expReq = !outst && !buffered && !br;
      chk($sformatf("r%0d.req", k), imemIf.imem_req, expReq);
      if (expReq) chk($sformatf("r%0d.addr", k), imemIf.imem_addr, mPc);
      if (imemIf.imem_req) begin pend = 1'b1; pendCnt = $urandom_range(1, 4); end

      delivered = 1'b0; dW = 0; dPc = 0;
      if (br) begin
        if (outst && rv) begin outst = 0; disc = 0; end
        else if (outst) disc = 1;
        buffered = 0;
        mPc = {tgt[31:2], 2'b00};
      end else if (expReq) begin
        outst = 1;
      end else if (outst && rv) begin
        outst = 0;
        if (disc) disc = 0;
        else if (st) begin buffered = 1; bufW = rd; end
        else begin delivered = 1; dW = rd; dPc = mPc; mPc = mPc + 32'd4; end
      end else if (buffered && !st) begin
        delivered = 1; dW = bufW; dPc = mPc; mPc = mPc + 32'd4; buffered = 0;
      end
      if (fl) begin eI = N; eV = 0; ePc = 0; eP4 = 0; end
      else if (!st) begin
        if (delivered) begin eI = dW; eV = 1; ePc = dPc; eP4 = dPc + 32'd4; end
        else begin eI = N; eV = 0; end
      end

      @(posedge clk); #1;
      chk($sformatf("r%0d.instr", k), InstrD, eI);
      chk($sformatf("r%0d.valid", k), ValidD, eV);
      if (eV || fl) begin
        chk($sformatf("r%0d.pcd", k), PCD, ePc);
        chk($sformatf("r%0d.p4", k), PCPlus4D, eP4);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
